// File: rtl/seq_shift_mult.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement, WIDTH x WIDTH -> 2*WIDTH.
// Latency: done pulses c+1 cycles after the capture edge (c = significant bits of |b|; 1 cycle for a zero operand).
// Backpressure: start is sampled only while ready; requests during CALC/DONE are dropped, not queued.
module seq_shift_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] r
);

    localparam int RW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state;
    logic [RW-1:0]    mcand;
    logic [RW-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic             neg;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [RW-1:0]    acc_sum;
    logic [RW-1:0]    acc_neg;
    logic [WIDTH-1:0] mplier_shr;

    // Operand magnitudes and the next accumulator value; the most negative
    // operand negates to itself in WIDTH bits, which reads as 2^(WIDTH-1) unsigned.
    always_comb begin
        mag_a      = (signed_mode && a_in[WIDTH-1]) ? ((~a_in) + WIDTH'(1)) : a_in;
        mag_b      = (signed_mode && b_in[WIDTH-1]) ? ((~b_in) + WIDTH'(1)) : b_in;
        acc_sum    = acc + (mplier[0] ? mcand : '0);
        acc_neg    = (~acc_sum) + RW'(1);
        mplier_shr = mplier >> 1;
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_CALC);
    assign done  = (state == S_DONE);

    // Control FSM and datapath: capture in IDLE, shift-add in CALC, publish r only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            r      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        if ((mag_a == '0) || (mag_b == '0)) begin
                            // Zero product: skip CALC, sign is irrelevant.
                            neg   <= 1'b0;
                            r     <= '0;
                            state <= S_DONE;
                        end else begin
                            neg   <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shr;
                    // Stop as soon as no multiplier bits remain.
                    if (mplier_shr == '0) begin
                        r     <= neg ? acc_neg : acc_sum;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_mult.sv
// Bench for seq_shift_mult: directed 8-bit vectors plus a 16-bit run with start held high.
// Latency: checks done timing against c+1 derived from operand magnitudes.
// Backpressure: exercises dropped starts during CALC and back-to-back acceptance.
module tb_seq_shift_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  st  = 2'b00;
    logic [1:0]  smv = 2'b00;
    logic [7:0]  av8 = '0;
    logic [7:0]  bv8 = '0;
    logic [15:0] av16 = '0;
    logic [15:0] bv16 = '0;
    logic [1:0]  rdy, bsy, dn;
    logic [15:0] r8;
    logic [31:0] r16;

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    seq_shift_mult #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st[0]), .signed_mode(smv[0]),
        .a_in(av8), .b_in(bv8),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .r(r8)
    );

    seq_shift_mult #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st[1]), .signed_mode(smv[1]),
        .a_in(av16), .b_in(bv16),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .r(r16)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference product from plain integer arithmetic, plus the CALC cycle count.
    task automatic ref_mult(input int w, input bit sm, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] p, output int c);
        longint mask, mask2, sa, sb, prod, mb;
        mask  = (64'sd1 <<< w) - 1;
        mask2 = (64'sd1 <<< (2 * w)) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sm && ((sa >>> (w - 1)) & 1) == 1) sa = sa - (64'sd1 <<< w);
        if (sm && ((sb >>> (w - 1)) & 1) == 1) sb = sb - (64'sd1 <<< w);
        prod = sa * sb;
        p = 64'(prod & mask2);
        mb = (sb < 0) ? -sb : sb;
        c = 0;
        while (mb != 0) begin
            c++;
            mb = mb >>> 1;
        end
        if (sa == 0) c = 0;
    endtask

    // Model timeline: cycles since capture and the cycle in which done must appear.
    int          m_cyc [2] = '{0, 0};
    int          m_tgt [2] = '{1, 1};
    logic [63:0] m_r   [2] = '{64'd0, 64'd0};
    logic [63:0] m_p   [2] = '{64'd0, 64'd0};

    always @(posedge clk) begin : model
        logic [63:0] p;
        int c;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cyc[i] = 0;
                m_r[i]   = '0;
            end else if (m_cyc[i] == 0) begin
                if (st[i]) begin
                    if (i == 0) ref_mult(8, smv[0], {56'd0, av8}, {56'd0, bv8}, p, c);
                    else        ref_mult(16, smv[1], {48'd0, av16}, {48'd0, bv16}, p, c);
                    m_p[i]   = p;
                    m_tgt[i] = c + 1;
                    m_cyc[i] = 1;
                    if (m_tgt[i] == 1) m_r[i] = p;
                end
            end else if (m_cyc[i] == m_tgt[i]) begin
                m_cyc[i] = 0;
            end else begin
                m_cyc[i]++;
                if (m_cyc[i] == m_tgt[i]) m_r[i] = m_p[i];
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cmp8 ready", {63'd0, rdy[0]}, {63'd0, m_cyc[0] == 0});
            check("cmp8 busy",  {63'd0, bsy[0]}, {63'd0, m_cyc[0] != 0 && m_cyc[0] < m_tgt[0]});
            check("cmp8 done",  {63'd0, dn[0]},  {63'd0, m_cyc[0] != 0 && m_cyc[0] == m_tgt[0]});
            check("cmp8 r",     {48'd0, r8},     m_r[0]);
            check("cmp16 ready", {63'd0, rdy[1]}, {63'd0, m_cyc[1] == 0});
            check("cmp16 busy",  {63'd0, bsy[1]}, {63'd0, m_cyc[1] != 0 && m_cyc[1] < m_tgt[1]});
            check("cmp16 done",  {63'd0, dn[1]},  {63'd0, m_cyc[1] != 0 && m_cyc[1] == m_tgt[1]});
            check("cmp16 r",     {32'd0, r16},    m_r[1]);
        end
    end

    // One 8-bit multiply with literal expectations; optional extra start/operand churn during CALC.
    task automatic run8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] er, input int el, input bit disturb, input string nm);
        int cyc;
        int nbusy;
        @(negedge clk);
        smv[0] = sm; av8 = a; bv8 = b; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        cyc = 1;
        nbusy = 0;
        while (!dn[0] && cyc < 60) begin
            if (bsy[0]) nbusy++;
            if (disturb && cyc == 2) begin
                st[0] = 1'b1; av8 = 8'h01; bv8 = 8'h02; smv[0] = ~sm;
            end else if (disturb && cyc == 3) begin
                st[0] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, 64'(cyc), 64'(el));
        check({nm, " busy cycles"}, 64'(nbusy), 64'(el - 1));
        check({nm, " r"}, {48'd0, r8}, {48'd0, er});
        @(negedge clk);
        check({nm, " ready after"}, {63'd0, rdy[0]}, 64'd1);
    endtask

    initial begin : stim
        logic [63:0] p;
        int c;
        int ndone;
        int nops;
        int budget;
        logic [15:0] ta [6];
        logic [15:0] tb [6];
        bit          ts [6];
        ta = '{16'h0000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0001};
        tb = '{16'h0005, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
        ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset ready8", {63'd0, rdy[0]}, 64'd1);
        check("reset busy8",  {63'd0, bsy[0]}, 64'd0);
        check("reset done8",  {63'd0, dn[0]},  64'd0);
        check("reset r8",     {48'd0, r8},     64'd0);
        check("reset r16",    {32'd0, r16},    64'd0);
        armed = 1'b1;

        // Pin the model against hand-computed products.
        ref_mult(8, 1'b1, 64'h80, 64'h80, p, c);
        check("ref -128sq p", p, 64'h4000);
        check("ref -128sq c", 64'(c), 64'd8);
        ref_mult(8, 1'b1, 64'hFD, 64'h07, p, c);
        check("ref -3x7 p", p, 64'hFFEB);
        check("ref -3x7 c", 64'(c), 64'd3);
        ref_mult(16, 1'b1, 64'h7FFF, 64'h8000, p, c);
        check("ref16 max*min p", p, 64'hC0008000);

        run8(1'b0, 8'd3,  8'd5,  16'd15,   4, 1'b0, "u3x5");
        run8(1'b1, 8'h80, 8'h80, 16'h4000, 9, 1'b0, "s-128sq");
        run8(1'b1, 8'hFD, 8'h07, 16'hFFEB, 4, 1'b0, "s-3x7");
        run8(1'b0, 8'h00, 8'hFF, 16'h0000, 1, 1'b0, "zero_a");
        run8(1'b0, 8'd3,  8'd5,  16'd15,   4, 1'b0, "u3x5b");
        run8(1'b0, 8'hFF, 8'h00, 16'h0000, 1, 1'b0, "zero_b");
        run8(1'b1, 8'h7F, 8'h80, 16'hC080, 9, 1'b0, "s127x-128");
        run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 9, 1'b1, "u255sq_churn");

        // Reset in the 4th CALC cycle of 255x255.
        @(negedge clk);
        smv[0] = 1'b0; av8 = 8'hFF; bv8 = 8'hFF; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-rst busy", {63'd0, bsy[0]}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst ready", {63'd0, rdy[0]}, 64'd1);
        check("rst busy",  {63'd0, bsy[0]}, 64'd0);
        check("rst done",  {63'd0, dn[0]},  64'd0);
        check("rst r",     {48'd0, r8},     64'd0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (dn[0]) ndone++;
        end
        check("rst no done", 64'(ndone), 64'd0);
        run8(1'b0, 8'd2, 8'd2, 16'd4, 3, 1'b0, "post_rst 2x2");

        // 16-bit run with start held high; new operands on each ready cycle.
        st[1] = 1'b1;
        nops = 0;
        ndone = 0;
        budget = 0;
        while (ndone < 40 && budget < 6000) begin
            if (rdy[1]) begin
                if (nops < 6) begin
                    av16 = ta[nops]; bv16 = tb[nops]; smv[1] = ts[nops];
                end else begin
                    av16 = 16'($urandom);
                    bv16 = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
                    smv[1] = 1'($urandom_range(0, 1));
                end
                nops++;
            end
            @(negedge clk);
            budget++;
            if (dn[1]) ndone++;
        end
        st[1] = 1'b0;
        check("w16 done count", 64'(ndone), 64'd40);
        repeat (20) @(negedge clk);
        check("w16 idle at end", {63'd0, rdy[1]}, 64'd1);

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
